// File: rtl/qr_sample.sv
// qr_sample -- QR grid sampler.
//
// Sits after the finder-pattern search. On a start pulse it latches the
// code origin (tile address + pixel position inside the tile) and the
// module scale. It then walks the 25x25 module grid, issuing one image SRAM
// read per module, and emits the grid one 25-bit row at a time. Finally it
// pulses done.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle start pulse (ignored while busy)
//   scale      : 1 = 1 pixel per module, 0 = 2 pixels per module
//   find_addr  : top-left tile address, [4:0]=tile column, [9:5]=tile row
//   find_pos   : pixel inside that tile, [1:0]=x, [3:2]=y
//   sram_rdata : 4x4 tile read data, bit 4*(y%4)+(x%4), one-cycle latency
//   sram_raddr : registered SRAM read address
//   row_data   : sampled row, bit c = module column c (1 = dark)
//   row_idx    : row number of row_data
//   row_valid  : one-cycle strobe for row_data/row_idx
//   busy       : high from LOAD through DONE
//   done       : one-cycle pulse when the grid is complete
module qr_sample #(
    parameter int GRID      = 25,
    parameter int IMG_TILES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        scale,
    input  logic [9:0]  find_addr,
    input  logic [3:0]  find_pos,
    input  logic [15:0] sram_rdata,
    output logic [9:0]  sram_raddr,
    output logic [24:0] row_data,
    output logic [4:0]  row_idx,
    output logic        row_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST    = 5'(GRID - 1);
    localparam logic [7:0] IMG_PIX = 8'(IMG_TILES * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x0_q, x0_d;
    logic [7:0]  y0_q, y0_d;
    logic        scale_q, scale_d;
    // Coordinates of the module whose address is currently on sram_raddr.
    logic [4:0]  r_q, r_d;
    logic [4:0]  c_q, c_d;
    logic [7:0]  px_q, px_d;
    logic [7:0]  py_q, py_d;
    logic [9:0]  raddr_q, raddr_d;
    // Capture stage: describes the module whose data is on sram_rdata now.
    logic        cap_valid_q, cap_valid_d;
    logic [3:0]  cap_sel_q, cap_sel_d;
    logic        cap_oob_q, cap_oob_d;
    logic [4:0]  cap_c_q, cap_c_d;
    logic [4:0]  cap_r_q, cap_r_d;
    logic [24:0] shift_q, shift_d;
    logic [24:0] row_data_q, row_data_d;
    logic [4:0]  row_idx_q, row_idx_d;
    logic        row_valid_q, row_valid_d;

    logic [7:0]  pitch;
    logic [7:0]  load_x0;
    logic [7:0]  load_y0;
    logic        sample;

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        scale_d     = scale_q;
        r_d         = r_q;
        c_d         = c_q;
        px_d        = px_q;
        py_d        = py_q;
        raddr_d     = raddr_q;
        cap_valid_d = (state_q == S_SCAN);
        cap_sel_d   = {py_q[1:0], px_q[1:0]};
        cap_oob_d   = (px_q >= IMG_PIX) || (py_q >= IMG_PIX);
        cap_c_d     = c_q;
        cap_r_d     = r_q;
        shift_d     = shift_q;
        row_data_d  = row_data_q;
        row_idx_d   = row_idx_q;
        row_valid_d = 1'b0;
        sample      = 1'b0;

        pitch   = scale_q ? 8'd1 : 8'd2;
        load_x0 = {1'b0, find_addr[4:0], 2'b00} + {6'b0, find_pos[1:0]};
        load_y0 = {1'b0, find_addr[9:5], 2'b00} + {6'b0, find_pos[3:2]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Module (0,0) address is prepared here so it is on the bus
                // in the first SCAN cycle.
                x0_d    = load_x0;
                y0_d    = load_y0;
                scale_d = scale;
                r_d     = 5'd0;
                c_d     = 5'd0;
                px_d    = load_x0;
                py_d    = load_y0;
                raddr_d = {load_y0[6:2], load_x0[6:2]};
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (r_q == LAST && c_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    if (c_q == LAST) begin
                        c_d  = 5'd0;
                        r_d  = r_q + 5'd1;
                        px_d = x0_q;
                        py_d = py_q + pitch;
                    end else begin
                        c_d  = c_q + 5'd1;
                        px_d = px_q + pitch;
                    end
                    // Off-image pixels still get a (truncated) read so the
                    // schedule never changes; the sample is zeroed later.
                    raddr_d = {py_d[6:2], px_d[6:2]};
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cap_valid_q) begin
            sample  = sram_rdata[cap_sel_q] & ~cap_oob_q;
            // Right shift: column 0 enters first and ends up in bit 0.
            shift_d = {sample, shift_q[24:1]};
            if (cap_c_q == LAST) begin
                row_data_d  = shift_d;
                row_idx_d   = cap_r_q;
                row_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            scale_q     <= 1'b0;
            r_q         <= '0;
            c_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            raddr_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_sel_q   <= '0;
            cap_oob_q   <= 1'b0;
            cap_c_q     <= '0;
            cap_r_q     <= '0;
            shift_q     <= '0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            scale_q     <= scale_d;
            r_q         <= r_d;
            c_q         <= c_d;
            px_q        <= px_d;
            py_q        <= py_d;
            raddr_q     <= raddr_d;
            cap_valid_q <= cap_valid_d;
            cap_sel_q   <= cap_sel_d;
            cap_oob_q   <= cap_oob_d;
            cap_c_q     <= cap_c_d;
            cap_r_q     <= cap_r_d;
            shift_q     <= shift_d;
            row_data_q  <= row_data_d;
            row_idx_q   <= row_idx_d;
            row_valid_q <= row_valid_d;
        end
    end

    assign sram_raddr = raddr_q;
    assign row_data   = row_data_q;
    assign row_idx    = row_idx_q;
    assign row_valid  = row_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_qr_sample.sv
// tb_qr_sample -- directed bench for qr_sample with a one-cycle-latency
// SRAM model holding a 128x128 1-bit image in 4x4 tiles.
module tb_qr_sample;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        scale = 1'b0;
    logic [9:0]  find_addr = '0;
    logic [3:0]  find_pos = '0;
    logic [15:0] sram_rdata;
    logic [9:0]  sram_raddr;
    logic [24:0] row_data;
    logic [4:0]  row_idx;
    logic        row_valid;
    logic        busy;
    logic        done;

    qr_sample dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .scale      (scale),
        .find_addr  (find_addr),
        .find_pos   (find_pos),
        .sram_rdata (sram_rdata),
        .sram_raddr (sram_raddr),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_valid  (row_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    always @(posedge clk) sram_rdata <= mem[sram_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [24:0] got_row [25];
    int          got_cyc [25];
    int          n_valid;
    int          n_done;
    int          done_rel;
    int          busy_err;
    logic [9:0]  addr2;
    logic [9:0]  addr3;

    localparam logic [24:0] CHK_EVEN = 25'h1555555;
    localparam logic [24:0] CHK_ODD  = 25'h0AAAAAA;

    task automatic clear_mem(input logic [15:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    task automatic set_pixel(input int x, input int y, input logic v);
        logic [6:0] xx;
        logic [6:0] yy;
        xx = 7'(x);
        yy = 7'(y);
        mem[{yy[6:2], xx[6:2]}][{yy[1:0], xx[1:0]}] = v;
    endtask

    task automatic load_checker();
        clear_mem(16'h0000);
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 25; c++)
                set_pixel(8 + c, 4 + r, ((r + c) % 2) == 0);
    endtask

    function automatic logic qr_ref(input int r, input int c);
        return ((r * 7 + c * 3 + r * c) % 5) < 2;
    endfunction

    // Starts a grid and observes it until one cycle after the expected done.
    // inj_a/inj_b: relative cycles at which extra start pulses are driven.
    task automatic run_grid(input logic [9:0] fa, input logic [3:0] fp, input logic sc,
                            input int inj_a, input int inj_b);
        int c0;
        int rel;
        for (int i = 0; i < 25; i++) begin
            got_row[i] = '0;
            got_cyc[i] = -1;
        end
        n_valid = 0;
        n_done = 0;
        done_rel = -1;
        busy_err = 0;
        @(negedge clk);
        find_addr = fa;
        find_pos = fp;
        scale = sc;
        start = 1'b1;
        c0 = cyc;
        rel = 0;
        while (rel < 629) begin
            @(negedge clk);
            rel = cyc - c0;
            start = (rel == inj_a) || (rel == inj_b);
            if (rel == 2) begin
                // Inputs must be ignored once LOAD has passed.
                find_addr = ~fa;
                find_pos = ~fp;
                scale = ~sc;
                addr2 = sram_raddr;
            end
            if (rel == 3) addr3 = sram_raddr;
            if (row_valid) begin
                if (n_valid < 25 && row_idx < 25) begin
                    got_row[row_idx] = row_data;
                    got_cyc[row_idx] = rel;
                end
                n_valid++;
            end
            if (done) begin
                n_done++;
                done_rel = rel;
            end
            if (busy !== ((rel >= 1) && (rel <= 628))) busy_err++;
        end
        start = 1'b0;
        $display("grid addr=%h pos=%h scale=%0d rows=%0d done_at=%0d", fa, fp, sc, n_valid, done_rel);
    endtask

    task automatic test_reset();
        int bad;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sram_raddr, row_data, row_idx, row_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got raddr=%h row=%h idx=%0d v=%b busy=%b done=%b required all 0",
                     sram_raddr, row_data, row_idx, row_valid, busy, done);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sram_raddr !== 10'd0 || busy !== 1'b0 || row_valid !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_quiet: got %0d active cycles required 0", bad);
        end
        $display("reset/idle observed 100 cycles");
    endtask

    task automatic test_scale1();
        logic [24:0] exp;
        load_checker();
        run_grid(10'h022, 4'h0, 1'b1, -1, -1);
        for (int r = 0; r < 25; r++) begin
            exp = (r % 2 == 0) ? CHK_EVEN : CHK_ODD;
            checks++;
            if (got_row[r] !== exp || got_cyc[r] != 28 + 25 * r) begin
                failures++;
                $display("FAIL scale1_row%0d: got %h at %0d required %h at %0d",
                         r, got_row[r], got_cyc[r], exp, 28 + 25 * r);
            end
        end
        checks++;
        if (n_valid != 25 || n_done != 1 || done_rel != 628 || busy_err != 0) begin
            failures++;
            $display("FAIL scale1_done: got valid=%0d done=%0d at %0d busy_err=%0d required 25 1 628 0",
                     n_valid, n_done, done_rel, busy_err);
        end
    endtask

    task automatic test_scale0();
        logic [24:0] exp;
        clear_mem(16'h0000);
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 25; c++)
                for (int d = 0; d < 4; d++)
                    set_pixel(6 + 2 * c + (d % 2), 5 + 2 * r + (d / 2), qr_ref(r, c));
        run_grid(10'h021, 4'b0110, 1'b0, -1, -1);
        checks++;
        if (addr2 !== 10'h021 || addr3 !== 10'h022) begin
            failures++;
            $display("FAIL scale0_addr: got %h,%h required 021,022", addr2, addr3);
        end
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < 25; c++) exp[c] = qr_ref(r, c);
            checks++;
            if (got_row[r] !== exp) begin
                failures++;
                $display("FAIL scale0_row%0d: got %h required %h", r, got_row[r], exp);
            end
        end
        checks++;
        if (n_valid != 25 || done_rel != 628) begin
            failures++;
            $display("FAIL scale0_done: got valid=%0d done_at=%0d required 25 628", n_valid, done_rel);
        end
    endtask

    task automatic test_clip();
        logic [24:0] exp;
        clear_mem(16'hFFFF);
        run_grid(10'h339, 4'h0, 1'b0, -1, -1);
        for (int r = 0; r < 25; r++) begin
            exp = (r < 14) ? 25'h0003FFF : 25'h0;
            checks++;
            if (got_row[r] !== exp) begin
                failures++;
                $display("FAIL clip_row%0d: got %h required %h", r, got_row[r], exp);
            end
        end
    endtask

    task automatic test_restart();
        load_checker();
        // Extra starts while busy and in the done cycle must both be ignored.
        run_grid(10'h022, 4'h0, 1'b1, 300, 628);
        checks++;
        if (got_cyc[0] != 28 || got_cyc[24] != 628 || got_row[13] !== CHK_ODD) begin
            failures++;
            $display("FAIL ignore_timing: got row0@%0d row24@%0d row13=%h required 28 628 %h",
                     got_cyc[0], got_cyc[24], got_row[13], CHK_ODD);
        end
        checks++;
        if (n_valid != 25 || n_done != 1 || done_rel != 628 || busy_err != 0) begin
            failures++;
            $display("FAIL ignore_done: got valid=%0d done=%0d at %0d busy_err=%0d required 25 1 628 0",
                     n_valid, n_done, done_rel, busy_err);
        end
        // Starts two cycles after the previous done.
        run_grid(10'h022, 4'h0, 1'b1, -1, -1);
        checks++;
        if (got_cyc[0] != 28 || got_row[0] !== CHK_EVEN || done_rel != 628) begin
            failures++;
            $display("FAIL restart: got row0=%h at %0d done_at=%0d required %h at 28 done 628",
                     got_row[0], got_cyc[0], done_rel, CHK_EVEN);
        end
    endtask

    task automatic test_abort();
        int c0;
        int rel;
        int bad;
        logic was_busy;
        logic [24:0] exp;
        load_checker();
        @(negedge clk);
        find_addr = 10'h022;
        find_pos = 4'h0;
        scale = 1'b1;
        start = 1'b1;
        c0 = cyc;
        rel = 0;
        while (rel < 200) begin
            @(negedge clk);
            rel = cyc - c0;
            start = 1'b0;
        end
        was_busy = busy;
        rst = 1'b1;
        #1;
        checks++;
        if (!was_busy || {sram_raddr, row_data, row_idx, row_valid, busy, done} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got busy_before=%b raddr=%h row=%h idx=%0d busy=%b required 1 and all 0",
                     was_busy, sram_raddr, row_data, row_idx, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (row_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d active cycles required 0", bad);
        end
        $display("abort at cycle 200 observed");
        run_grid(10'h022, 4'h0, 1'b1, -1, -1);
        for (int r = 0; r < 25; r += 6) begin
            exp = (r % 2 == 0) ? CHK_EVEN : CHK_ODD;
            checks++;
            if (got_row[r] !== exp) begin
                failures++;
                $display("FAIL abort_rerun_row%0d: got %h required %h", r, got_row[r], exp);
            end
        end
        checks++;
        if (n_valid != 25 || n_done != 1 || done_rel != 628) begin
            failures++;
            $display("FAIL abort_rerun_done: got valid=%0d done=%0d at %0d required 25 1 628",
                     n_valid, n_done, done_rel);
        end
    endtask

    initial begin
        clear_mem(16'h0000);
        test_reset();
        test_scale1();
        test_scale0();
        test_clip();
        test_restart();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
